// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline control unit.
package pipe_ctrl_pkg;

  // Core-wide encodings used by every stage.
  localparam logic        STOP      = 1'b1;
  localparam logic        RST_EN    = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Bit positions inside the STALL vector.
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  // A stall request stops its own stage and every stage upstream of it.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } pipe_ctrl_state_t;

  // Deepest requesting stage wins; WB is never stopped.
  function automatic logic [5:0] stall_merge(input logic if_req, input logic id_req,
                                             input logic ex_req, input logic mem_req);
    logic [5:0] s;
    s = STALL_NONE;
    if (mem_req)     s = STALL_MEM;
    else if (ex_req) s = STALL_EX;
    else if (id_req) s = STALL_ID;
    else if (if_req) s = STALL_IF;
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages and the control unit.
// EXC_NEW_PC is meaningful only in a cycle where EXC_VALID=1; there is no
// back-pressure on it -- the control unit either flushes that same cycle or
// latches the target, so the MEM stage may present an exception for a single
// cycle and never needs to wait for an acknowledge.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  logic             IF_STALL_REQ;
  logic             ID_STALL_REQ;
  logic             EX_STALL_REQ;
  logic             MEM_STALL_REQ;
  logic             EXC_VALID;
  logic [31:0]      EXC_NEW_PC;
  logic             PERF_CLR;
  logic [5:0]       STALL;
  logic             FLUSH;
  logic [31:0]      NEW_PC;
  logic [CNT_W-1:0] STALL_CNT;
  logic             STALL_TIMEOUT;
  pipe_ctrl_state_t state;

  modport master (
    output IF_STALL_REQ, ID_STALL_REQ, EX_STALL_REQ, MEM_STALL_REQ,
    output EXC_VALID, EXC_NEW_PC, PERF_CLR,
    input  STALL, FLUSH, NEW_PC, STALL_CNT, STALL_TIMEOUT, state
  );

  modport slave (
    input  IF_STALL_REQ, ID_STALL_REQ, EX_STALL_REQ, MEM_STALL_REQ,
    input  EXC_VALID, EXC_NEW_PC, PERF_CLR,
    output STALL, FLUSH, NEW_PC, STALL_CNT, STALL_TIMEOUT, state
  );

endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Stall performance counter and consecutive-stall watchdog.
module stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stalled,
  input  logic             flush,
  input  logic             clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout
);

  // run_len never needs to exceed TIMEOUT_CYCLES-1, it parks there once reached.
  localparam int               RL_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RL_W-1:0]  RL_LAST = RL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [RL_W-1:0] run_len;

  // Length of the current unbroken stall run, restarted by any idle or flush cycle.
  always_ff @(posedge clk) begin
    if (rst == RST_EN) begin
      run_len <= '0;
    end else if (!stalled || flush) begin
      run_len <= '0;
    end else if (run_len != RL_LAST) begin
      run_len <= run_len + 1'b1;
    end
  end

  // Saturating count of cycles in which the PC was held; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst == RST_EN) begin
      stall_cnt <= '0;
    end else if (clr) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Sticky timeout flag; clear beats a simultaneous set.
  always_ff @(posedge clk) begin
    if (rst == RST_EN) begin
      stall_timeout <= 1'b0;
    end else if (clr) begin
      stall_timeout <= 1'b0;
    end else if (stalled && !flush && (run_len == RL_LAST)) begin
      stall_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stall requests, sequences exception flushes
// (deferring them behind a MEM stall) and hosts the stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic     CLK,
  input  logic     RST,
  pipe_ctrl_if.slave bus
);

  pipe_ctrl_state_t state;
  logic [31:0]      pend_pc;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;

  // Same-cycle stall/flush decision so a load-use stall needs no extra cycle.
  always_comb begin
    stall  = STALL_NONE;
    flush  = 1'b0;
    new_pc = ZERO_WORD;
    if (RST != RST_EN) begin
      case (state)
        RUN: begin
          if (bus.EXC_VALID && !bus.MEM_STALL_REQ) begin
            flush  = 1'b1;
            new_pc = bus.EXC_NEW_PC;
          end else begin
            // An exception blocked by MEM still yields the MEM stall pattern here.
            stall = stall_merge(bus.IF_STALL_REQ, bus.ID_STALL_REQ,
                                bus.EX_STALL_REQ, bus.MEM_STALL_REQ);
          end
        end
        PEND: begin
          if (bus.MEM_STALL_REQ) begin
            stall = STALL_MEM;
          end else begin
            flush  = 1'b1;
            new_pc = pend_pc;
          end
        end
        default: begin
          stall = STALL_NONE;
        end
      endcase
    end
  end

  // Exception sequencer: park the first target while MEM is stalled, release on drop.
  always_ff @(posedge CLK) begin
    if (RST == RST_EN) begin
      state   <= RUN;
      pend_pc <= ZERO_WORD;
    end else begin
      case (state)
        RUN: begin
          if (bus.EXC_VALID && bus.MEM_STALL_REQ) begin
            state   <= PEND;
            pend_pc <= bus.EXC_NEW_PC;
          end
        end
        PEND: begin
          if (!bus.MEM_STALL_REQ) begin
            state   <= RUN;
            pend_pc <= ZERO_WORD;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign bus.STALL  = stall;
  assign bus.FLUSH  = flush;
  assign bus.NEW_PC = new_pc;
  assign bus.state  = state;

  // Every nonzero STALL encoding stops the PC, so one "stalled" bit serves both
  // the PC-stall counter and the nonzero-STALL watchdog.
  stall_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk          (CLK),
    .rst          (RST),
    .stalled      (stall[STG_PC] == STOP),
    .flush        (flush),
    .clr          (bus.PERF_CLR),
    .stall_cnt    (bus.STALL_CNT),
    .stall_timeout(bus.STALL_TIMEOUT)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vectors, per-cycle model compare, literal pins.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int T_CYC = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk;
  logic rst;
  pipe_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_ctrl #(
    .TIMEOUT_CYCLES(T_CYC),
    .CNT_W         (CW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int total;
  int bad;
  logic chk_en;

  // Clock/reset block.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs just after the edge, settle, return.
  task automatic step(input logic r, input logic ifr, input logic idr, input logic exr,
                      input logic memr, input logic exc, input logic [31:0] pc,
                      input logic clr);
    @(posedge clk);
    #1;
    rst               = r;
    bus.IF_STALL_REQ  = ifr;
    bus.ID_STALL_REQ  = idr;
    bus.EX_STALL_REQ  = exr;
    bus.MEM_STALL_REQ = memr;
    bus.EXC_VALID     = exc;
    bus.EXC_NEW_PC    = pc;
    bus.PERF_CLR      = clr;
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0, 0);
  endtask

  // Behavioural model: a pending-exception flag, a running stall streak and
  // plain integer counters, advanced once per cycle from the applied inputs.
  logic        m_pending;
  logic [31:0] m_pend_pc;
  int          m_cnt;
  int          m_streak;
  logic        m_to;

  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_pc;
  int          deepest;

  initial begin
    m_pending = 1'b0;
    m_pend_pc = 32'h0;
    m_cnt     = 0;
    m_streak  = 0;
    m_to      = 1'b0;
  end

  // Compare process: registered outputs against model state, then combinational
  // outputs against this cycle's expectation, then advance the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_cnt", 32'(bus.STALL_CNT), 32'(m_cnt));
      check("m_timeout", 32'(bus.STALL_TIMEOUT), 32'(m_to));
      e_stall = 6'b0;
      e_flush = 1'b0;
      e_pc    = 32'h0;
      if (rst) begin
        m_pending = 1'b0;
        m_pend_pc = 32'h0;
        m_cnt     = 0;
        m_streak  = 0;
        m_to      = 1'b0;
      end else begin
        deepest = bus.MEM_STALL_REQ ? 4 : bus.EX_STALL_REQ ? 3 :
                  bus.ID_STALL_REQ  ? 2 : bus.IF_STALL_REQ ? 1 : 0;
        if (deepest > 0) e_stall = 6'((1 << (deepest + 1)) - 1);
        if (m_pending) begin
          if (!bus.MEM_STALL_REQ) begin
            e_flush   = 1'b1;
            e_pc      = m_pend_pc;
            m_pending = 1'b0;
          end
        end else if (bus.EXC_VALID) begin
          if (!bus.MEM_STALL_REQ) begin
            e_flush = 1'b1;
            e_pc    = bus.EXC_NEW_PC;
          end else begin
            m_pending = 1'b1;
            m_pend_pc = bus.EXC_NEW_PC;
          end
        end
        if (e_flush) e_stall = 6'b0;
        if (bus.PERF_CLR) m_cnt = 0;
        else if (e_stall != 6'b0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
        m_streak = (e_stall != 6'b0) ? m_streak + 1 : 0;
        if (bus.PERF_CLR) m_to = 1'b0;
        else if (m_streak >= T_CYC) m_to = 1'b1;
      end
      check("m_stall", 32'(bus.STALL), 32'(e_stall));
      check("m_flush", 32'(bus.FLUSH), 32'(e_flush));
      check("m_new_pc", bus.NEW_PC, e_pc);
    end
  end

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    chk_en            = 1'b0;
    total             = 0;
    bad               = 0;
    rst               = 1'b1;
    bus.IF_STALL_REQ  = 1'b0;
    bus.ID_STALL_REQ  = 1'b0;
    bus.EX_STALL_REQ  = 1'b0;
    bus.MEM_STALL_REQ = 1'b0;
    bus.EXC_VALID     = 1'b0;
    bus.EXC_NEW_PC    = 32'h0;
    bus.PERF_CLR      = 1'b0;

    // Reset: outputs held at zero even with a request present.
    step(1, 0, 1, 0, 0, 0, 32'h0, 0);
    chk_en = 1'b1;
    check("rst_stall", 32'(bus.STALL), 32'h0);
    check("rst_flush", 32'(bus.FLUSH), 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h0, 0);
    check("rst_cnt", 32'(bus.STALL_CNT), 32'h0);
    check("rst_timeout", 32'(bus.STALL_TIMEOUT), 32'h0);
    check("rst_new_pc", bus.NEW_PC, 32'h0);

    // Priority.
    step(0, 0, 1, 1, 0, 0, 32'h0, 0);
    check("prio_id_ex", 32'(bus.STALL), 32'h0F);
    step(0, 0, 1, 0, 0, 0, 32'h0, 0);
    check("prio_id", 32'(bus.STALL), 32'h07);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("prio_none", 32'(bus.STALL), 32'h00);
    check("cnt_after_prio", 32'(bus.STALL_CNT), 32'd2);

    // Unstalled exception flushes in the same cycle, overriding ID stall.
    step(0, 0, 1, 0, 0, 1, 32'hBFC0_0380, 0);
    check("exc_flush", 32'(bus.FLUSH), 32'h1);
    check("exc_new_pc", bus.NEW_PC, 32'hBFC0_0380);
    check("exc_stall", 32'(bus.STALL), 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("exc_flush_off", 32'(bus.FLUSH), 32'h0);

    // Deferred flush: first target wins, released the cycle MEM drops.
    step(0, 0, 0, 0, 1, 1, 32'h8000_0180, 0);
    check("dfr_flush0", 32'(bus.FLUSH), 32'h0);
    check("dfr_stall0", 32'(bus.STALL), 32'h1F);
    step(0, 0, 0, 0, 1, 1, 32'h0000_1234, 0);
    check("dfr_state", 32'(bus.state), 32'(PEND));
    check("dfr_stall1", 32'(bus.STALL), 32'h1F);
    step(0, 0, 0, 0, 1, 1, 32'h0000_1234, 0);
    check("dfr_flush2", 32'(bus.FLUSH), 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("dfr_flush", 32'(bus.FLUSH), 32'h1);
    check("dfr_new_pc", bus.NEW_PC, 32'h8000_0180);
    check("dfr_stall", 32'(bus.STALL), 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("dfr_once", 32'(bus.FLUSH), 32'h0);
    check("dfr_cnt", 32'(bus.STALL_CNT), 32'd5);

    // Counter: 5 IF stall cycles (broken so the watchdog stays quiet).
    step(0, 0, 0, 0, 0, 0, 32'h0, 1);
    idle(1);
    check("cnt_clr", 32'(bus.STALL_CNT), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 32'h0, 0);
    idle(1);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0, 0, 0, 32'h0, 0);
    idle(1);
    check("cnt_five", 32'(bus.STALL_CNT), 32'd5);
    check("cnt_no_to", 32'(bus.STALL_TIMEOUT), 32'h0);
    step(0, 1, 0, 0, 0, 0, 32'h0, 1);
    idle(1);
    check("cnt_clr_wins", 32'(bus.STALL_CNT), 32'd0);

    // Watchdog: 4 consecutive stall cycles set the flag after the 4th edge.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 32'h0, 0);
    check("wd_before", 32'(bus.STALL_TIMEOUT), 32'h0);
    idle(1);
    check("wd_set", 32'(bus.STALL_TIMEOUT), 32'h1);
    idle(1);
    check("wd_sticky", 32'(bus.STALL_TIMEOUT), 32'h1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 1);
    idle(1);
    check("wd_clr", 32'(bus.STALL_TIMEOUT), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 32'h0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 32'h0, 0);
    idle(1);
    check("wd_broken", 32'(bus.STALL_TIMEOUT), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 32'h0, 0);
    step(0, 0, 0, 1, 0, 0, 32'h0, 1);
    idle(1);
    check("wd_clr_wins", 32'(bus.STALL_TIMEOUT), 32'h0);

    // Counter saturation at the top of a 4-bit counter.
    step(0, 0, 0, 0, 0, 0, 32'h0, 1);
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 0, 0, 32'h0, 0);
    idle(1);
    check("cnt_sat", 32'(bus.STALL_CNT), 32'd15);
    step(0, 0, 0, 0, 0, 0, 32'h0, 1);

    // Reset while PEND discards the pending flush.
    step(0, 0, 0, 0, 1, 1, 32'h0000_0055, 0);
    check("rp_stall", 32'(bus.STALL), 32'h1F);
    step(1, 0, 0, 0, 1, 0, 32'h0, 0);
    check("rp_rst_stall", 32'(bus.STALL), 32'h0);
    check("rp_rst_flush", 32'(bus.FLUSH), 32'h0);
    step(0, 0, 0, 0, 0, 0, 32'h0, 0);
    check("rp_flush", 32'(bus.FLUSH), 32'h0);
    check("rp_new_pc", bus.NEW_PC, 32'h0);
    check("rp_stall0", 32'(bus.STALL), 32'h0);
    check("rp_cnt", 32'(bus.STALL_CNT), 32'd0);

    // Release from PEND overrides ID/EX requests arriving in the flush cycle.
    step(0, 0, 0, 0, 1, 1, 32'h0000_00A0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h0000_00B0, 0);
    step(0, 0, 1, 1, 0, 0, 32'h0, 0);
    check("ovr_flush", 32'(bus.FLUSH), 32'h1);
    check("ovr_new_pc", bus.NEW_PC, 32'h0000_00A0);
    check("ovr_stall", 32'(bus.STALL), 32'h0);
    idle(2);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline control unit for the 5-stage MIPS core.
- Merges per-stage stall requests into the global 6-bit STALL vector. Each inter-stage register takes its 2-bit slice {next_stage_stop, this_stage_stop}: pass when this stage runs, bubble when this stage stops but the next runs, hold when both stop.
- Sequences exception/ERET flushes, deferring them while MEM is stalled.
- Keeps a stall performance counter and a stall watchdog.

Parameters:
- TIMEOUT_CYCLES, 1024, consecutive nonzero-STALL cycles before STALL_TIMEOUT sets; legal range 2..2^16.
- CNT_W, 32, width of STALL_CNT.

Ports:
- CLK  in  1  core clock
- RST  in  1  synchronous reset, active-high (RST_EN); the only reset
- IF_STALL_REQ  in  1  IF stall request (icache miss)
- ID_STALL_REQ  in  1  ID stall request (load-use)
- EX_STALL_REQ  in  1  EX stall request (multi-cycle mul/div)
- MEM_STALL_REQ  in  1  MEM stall request (dcache busy)
- EXC_VALID  in  1  MEM-stage exception/ERET present this cycle
- EXC_NEW_PC  in  32  handler/EPC target, valid with EXC_VALID
- PERF_CLR  in  1  clears STALL_CNT and STALL_TIMEOUT
- STALL  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = STOP
- FLUSH  out  1  flush all pipe registers this cycle
- NEW_PC  out  32  PC to load when FLUSH=1, else ZERO_WORD
- STALL_CNT  out  CNT_W  cycles with STALL[0]=1, saturating
- STALL_TIMEOUT  out  1  sticky watchdog flag

Behaviour:
- STALL, FLUSH and NEW_PC are combinational from the inputs and the registered state, so a load-use stall takes effect in the same cycle it is requested.
- Stall priority: the deepest request wins.
  - MEM → 6'b011111
  - EX → 6'b001111
  - ID → 6'b000111
  - IF → 6'b000011
  - none → 6'b000000
  - WB (bit5) is never stopped.
- While RST=1: STALL=0, FLUSH=0, NEW_PC=0, STALL_CNT=0, STALL_TIMEOUT=0, state=RUN, internal counters 0.
- FSM states:
  - RUN
    - EXC_VALID=1 and MEM_STALL_REQ=0: FLUSH=1, NEW_PC=EXC_NEW_PC, STALL forced to 0 in that cycle; stay in RUN.
    - EXC_VALID=1 and MEM_STALL_REQ=1: latch EXC_NEW_PC into pend_pc, go to PEND; FLUSH=0, STALL=011111.
  - PEND
    - MEM_STALL_REQ=1: stay; STALL=011111; EXC_VALID ignored (first exception wins).
    - MEM_STALL_REQ=0: FLUSH=1, NEW_PC=pend_pc, STALL=0, go to RUN (flush exactly one cycle).
- FLUSH overrides all stall requests, including an IF/ID/EX request arriving in the flush cycle.
- Maximum flush latency after MEM_STALL_REQ drops: 0 cycles.
- STALL_CNT:
  - +1 per cycle with STALL[0]=1.
  - Saturates at 2^CNT_W-1.
  - PERF_CLR=1 loads 0 and wins over a simultaneous increment.
- Watchdog:
  - run_len counts consecutive cycles with STALL≠0; cleared on any cycle with STALL=0 or FLUSH=1.
  - If run_len==TIMEOUT_CYCLES-1 and STALL≠0 in the current cycle, STALL_TIMEOUT sets on the next edge.
  - STALL_TIMEOUT stays set until RST or PERF_CLR; PERF_CLR wins over a simultaneous set.
  - STALL_TIMEOUT has no effect on STALL.
- Reset in PEND: the pending flush is discarded and the FSM returns to RUN.

Decomposition:
- Shared package holds:
  - Stage index constants: STG_PC..STG_WB.
  - STALL encodings: STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM.
  - The pipe_ctrl_state_t enum {RUN, PEND}.
- Reuses the existing STOP, RST_EN and ZERO_WORD defines.
- One sub-module, stall_watchdog, holds run_len, STALL_CNT and STALL_TIMEOUT. Its inputs are stalled, flush and clr.

Test Plan:
- Priority: ID_STALL_REQ=1 and EX_STALL_REQ=1 together → STALL=001111. Then ID_STALL_REQ=1 alone → 000111. All requests 0 → 000000.
- Unstalled exception: EXC_VALID=1 with EXC_NEW_PC=0xBFC00380, MEM_STALL_REQ=0, ID_STALL_REQ=1 → same cycle FLUSH=1, NEW_PC=0xBFC00380, STALL=0. Next cycle FLUSH=0.
- Deferred flush:
  - Drive EXC_VALID=1 with EXC_NEW_PC=0x80000180 while MEM_STALL_REQ=1 for 3 cycles; during this window change EXC_NEW_PC to 0x1234.
  - Expect FLUSH=0 and STALL=011111 while stalled.
  - Drop MEM_STALL_REQ → FLUSH=1, NEW_PC=0x80000180, for one cycle only.
- Counter: 5 cycles of IF_STALL_REQ → STALL_CNT=5. Assert PERF_CLR together with a stall cycle → STALL_CNT=0.
- Watchdog with TIMEOUT_CYCLES=4:
  - EX_STALL_REQ held for 4 cycles → STALL_TIMEOUT=1 after the 4th edge.
  - With 3 stall cycles, 1 idle cycle, then 3 stall cycles → STALL_TIMEOUT stays 0.
- Reset mid-PEND: RST=1 for one cycle while in PEND, then MEM_STALL_REQ=0 → FLUSH stays 0, all outputs 0.
